// File: rtl/conv1_pkg.sv
// rtl/conv1_pkg.sv - shared widths, constants, load FSM states and block byte extract for conv1 MAC
package conv1_pkg;
   localparam int CH_NUM       = 4;
   localparam int ACT_PER_ADDR = 4;
   localparam int BW_PER_ACT   = 8;
   localparam int BW_PER_PARAM = 8;
   localparam int ACC_BW       = 22;
   localparam int BIAS_SHIFT   = 7;
   localparam int OUT_SHIFT    = 7;
   localparam int OUT_MAX      = 127;
   localparam int BLK_BW       = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
   localparam int KER_BW       = 9 * BW_PER_PARAM;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD_W,
      ST_LOAD_B,
      ST_READY
   } load_state_t;

   // Element ch*4+pos of a block; element 0 sits in the most significant byte.
   function automatic logic signed [BW_PER_ACT-1:0] blk_byte(input logic [BLK_BW-1:0] blk,
                                                              input int ch, input int pos);
      int idx;
      idx = ch * ACT_PER_ADDR + pos;
      return blk[BLK_BW-1-idx*BW_PER_ACT -: BW_PER_ACT];
   endfunction
endpackage

// File: rtl/conv1_pe.sv
// rtl/conv1_pe.sv - one output channel: 3x3x4 products, bias accumulate, round/ReLU/saturate
module conv1_pe
   import conv1_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en1,
   input  logic                    en2,
   input  logic                    en3,
   input  logic [BLK_BW-1:0]       tmp_a0,
   input  logic [BLK_BW-1:0]       tmp_a1,
   input  logic [BLK_BW-1:0]       tmp_a2,
   input  logic [BLK_BW-1:0]       tmp_a3,
   input  logic [KER_BW-1:0]       ker [CH_NUM],
   input  logic [BW_PER_PARAM-1:0] bias,
   output logic [BW_PER_PARAM-1:0] res
);
   localparam int NPROD   = CH_NUM * 9;
   localparam int PROD_BW = BW_PER_ACT + BW_PER_PARAM;
   localparam logic signed [ACC_BW-1:0] RND_ADD = ACC_BW'(2 ** (OUT_SHIFT - 1));

   logic [BLK_BW-1:0]          quad [4];
   logic signed [PROD_BW-1:0]  prod_d [NPROD];
   logic signed [PROD_BW-1:0]  prod_q [NPROD];
   logic signed [ACC_BW-1:0]   acc_d, acc_q, rnd, shr;
   logic [BW_PER_PARAM-1:0]    res_d;

   assign quad[0] = tmp_a0;
   assign quad[1] = tmp_a1;
   assign quad[2] = tmp_a2;
   assign quad[3] = tmp_a3;

   // Window row/col picks the quadrant with its high bit and the raster position with its low bit.
   always_comb begin
      for (int ic = 0; ic < CH_NUM; ic++) begin
         for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
               prod_d[ic*9+kr*3+kc] =
                  PROD_BW'(blk_byte(quad[(kr/2)*2+kc/2], ic, (kr%2)*2+kc%2)) *
                  PROD_BW'($signed(ker[ic][KER_BW-1-(kr*3+kc)*BW_PER_PARAM -: BW_PER_PARAM]));
            end
         end
      end
   end

   always_comb begin
      acc_d = ACC_BW'($signed(bias)) <<< BIAS_SHIFT;
      for (int i = 0; i < NPROD; i++) begin
         acc_d = acc_d + ACC_BW'(prod_q[i]);
      end
   end

   always_comb begin
      rnd = acc_q + RND_ADD;
      shr = rnd >>> OUT_SHIFT;
      if (shr[ACC_BW-1])
         res_d = '0;
      else if (shr > ACC_BW'(OUT_MAX))
         res_d = BW_PER_PARAM'(OUT_MAX);
      else
         res_d = shr[BW_PER_PARAM-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NPROD; i++) prod_q[i] <= '0;
         acc_q <= '0;
         res   <= '0;
      end else begin
         if (en1) prod_q <= prod_d;
         if (en2) acc_q  <= acc_d;
         if (en3) res    <= res_d;
      end
   end
endmodule

// File: rtl/conv1_mac_pipe.sv
// rtl/conv1_mac_pipe.sv - conv1 MAC pipeline top: parameter load FSM, parameter regs, valid pipe
module conv1_mac_pipe
   import conv1_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    w_start,
   input  logic                    w_valid,
   input  logic [KER_BW-1:0]       w_data,
   output logic                    w_ready,
   input  logic                    in_valid,
   input  logic [BLK_BW-1:0]       tmp_a0,
   input  logic [BLK_BW-1:0]       tmp_a1,
   input  logic [BLK_BW-1:0]       tmp_a2,
   input  logic [BLK_BW-1:0]       tmp_a3,
   output logic                    out_valid,
   output logic [BW_PER_PARAM-1:0] pipe3_c0,
   output logic [BW_PER_PARAM-1:0] pipe3_c1,
   output logic [BW_PER_PARAM-1:0] pipe3_c2,
   output logic [BW_PER_PARAM-1:0] pipe3_c3
);
   load_state_t             state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    w_we, b_we, accept;
   logic [2:0]              vld_q;
   logic [KER_BW-1:0]       w_q [CH_NUM][CH_NUM];
   logic [BW_PER_PARAM-1:0] b_q [CH_NUM];
   logic [BW_PER_PARAM-1:0] res [CH_NUM];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A start in any state restarts the weight sequence at beat 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_we    = 1'b0;
      b_we    = 1'b0;
      case (state_q)
         ST_IDLE, ST_READY: begin
            if (w_start) begin
               state_d = ST_LOAD_W;
               cnt_d   = '0;
            end
         end
         ST_LOAD_W: begin
            if (w_start) begin
               cnt_d = '0;
            end else if (w_valid) begin
               w_we  = 1'b1;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd15) state_d = ST_LOAD_B;
            end
         end
         ST_LOAD_B: begin
            if (w_start) begin
               state_d = ST_LOAD_W;
               cnt_d   = '0;
            end else if (w_valid) begin
               b_we    = 1'b1;
               state_d = ST_READY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign w_ready = (state_q == ST_READY);
   assign accept  = in_valid && w_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int oc = 0; oc < CH_NUM; oc++) begin
            b_q[oc] <= '0;
            for (int ic = 0; ic < CH_NUM; ic++) w_q[oc][ic] <= '0;
         end
      end else begin
         if (w_we) w_q[cnt_q[3:2]][cnt_q[1:0]] <= w_data;
         if (b_we) begin
            for (int oc = 0; oc < CH_NUM; oc++)
               b_q[oc] <= w_data[CH_NUM*BW_PER_PARAM-1-oc*BW_PER_PARAM -: BW_PER_PARAM];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= '0;
      else        vld_q <= {vld_q[1:0], accept};
   end

   assign out_valid = vld_q[2];

   for (genvar oc = 0; oc < CH_NUM; oc++) begin : g_pe
      conv1_pe u_pe (
         .clk    (clk),
         .rst_n  (rst_n),
         .en1    (accept),
         .en2    (vld_q[0]),
         .en3    (vld_q[1]),
         .tmp_a0 (tmp_a0),
         .tmp_a1 (tmp_a1),
         .tmp_a2 (tmp_a2),
         .tmp_a3 (tmp_a3),
         .ker    (w_q[oc]),
         .bias   (b_q[oc]),
         .res    (res[oc])
      );
   end

   assign pipe3_c0 = res[0];
   assign pipe3_c1 = res[1];
   assign pipe3_c2 = res[2];
   assign pipe3_c3 = res[3];
endmodule
